scoreboard_regfile: RTL
=======================

Name: scoreboard_regfile

Overview:
- Parametrised successor to the fixed-point register read stage.
- Holds the GPR file and a per-register pending-writeback scoreboard, reads up to NUM_OPS operands per issued instruction, and marks destination registers pending.
- Accepts NUM_WB writebacks per cycle and can optionally bypass same-cycle writeback data to reads.
- Sits between decode and the execution units.
- Adds a combinational stall, WAW protection, a flush and writeback forwarding.

Parameters:
- DATA_WIDTH, 64, register and operand width.
- ADDR_WIDTH, 5, register index width; NUM_REGS = 2**ADDR_WIDTH.
- NUM_OPS, 3, operand slots per instruction.
- NUM_WB, 2, writeback ports.
- BYPASS, 1; 1 forwards same-cycle writeback data to reads, 0 stalls instead.

Ports:
- clock_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- flush_i  in  1  clears all pending bits, drops the current request.
- valid_i  in  1  issue request present.
- opEnable_i  in  NUM_OPS  per-slot enable.
- opAddr_i  in  NUM_OPS*ADDR_WIDTH  slot k at bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- opUse_i  in  NUM_OPS*2  per slot: 0 imm, 1 read, 2 write, 3 read/write.
- opZeroIfR0_i  in  NUM_OPS  a read of register 0 returns 0.
- wbValid_i  in  NUM_WB  writeback strobes.
- wbAddr_i  in  NUM_WB*ADDR_WIDTH  writeback addresses.
- wbData_i  in  NUM_WB*DATA_WIDTH  writeback data.
- stall_o  out  1  combinational; the request is not accepted this cycle.
- valid_o  out  1  registered; operands valid.
- operand_o  out  NUM_OPS*DATA_WIDTH  operand values.
- operandEnable_o  out  NUM_OPS  registered copy of opEnable_i.
- operandWb_o  out  NUM_OPS  slot is a destination.
- destAddr_o  out  NUM_OPS*ADDR_WIDTH  destination register index per slot.

Behaviour:
- **Reset (reset_i=1 at posedge):**
  - Register file, pending table and all registered outputs go to 0.
  - Writebacks and requests in that cycle are ignored.
  - Reset wins over flush and everything else.
- **Writeback clear:** wbClear[r] = 1 when any enabled wb port j has wbAddr_i[j]==r.
- **Source hazard (slot k, use 1 or 3, not zero-forced):**
  - Hazard when pending[addr] and not (BYPASS and wbClear[addr]).
  - With BYPASS=0, a pending source always stalls.
- **Destination hazard (use 2 or 3):** hazard when pending[addr] and not wbClear[addr] (WAW).
- **Stall:** stall_o = valid_i & (flush_i | any hazard in an enabled slot). Accept = valid_i & !stall_o.
- **On accept, registered at next posedge, latency 1:**
  - valid_o=1.
  - Per slot: operandEnable_o=opEnable_i; disabled slots drive operand 0, Wb 0, dest 0.
  - use 0 or 2: operand = zero-extended address.
  - use 1 or 3: operand is chosen in this order:
    - 0 if opZeroIfR0_i and addr==0;
    - else bypass data from the highest-index wb port matching addr;
    - else the register file value.
  - use 2 or 3: operandWb_o=1, destAddr_o=addr, pending[addr] set.
  - use 0 or 1: operandWb_o=0.
- **Not accepted:** valid_o=0; other outputs hold their previous values.
- **Writeback update:**
  - Every posedge without reset: each valid wb port writes the file and clears pending.
  - Two ports to the same address: the highest index wins the data.
  - The same register is cleared by a writeback and set by an accepted issue in the same cycle: set wins (new producer).
  - Register 0 is an ordinary storage register; only opZeroIfR0_i forces it to 0.
- **Multiple slots:**
  - Two slots of one request naming the same destination: pending is set once.
  - A source and a destination may name the same register (read/write).
- **flush_i:**
  - Clears the whole pending table; the clear takes priority over a same-cycle issue set.
  - Writebacks still update file data.
  - valid_o=0 next cycle.
- **No backpressure from downstream:** a consumer must accept valid_o every cycle.

Test Plan:
1. Reset, write r5=0x1234 via wb0, then issue slot0 read r5 -> next cycle valid_o=1, operand0=0x1234, stall_o=0 throughout.
2. Issue slot0 write r7, then the next request reads r7 with no wb -> stall_o=1 held; at wb0 r7=0xAB that cycle:
   - BYPASS=1: accept, operand=0xAB.
   - BYPASS=0: stall that cycle, accept the next cycle.
3. wb0 and wb1 both write r3 (0x11, 0x22) in the same cycle -> a later read of r3 returns 0x22; pending[r3]=0.
4. Same cycle: wb0 clears r9 while an issue writes r9 -> pending[r9]=1 afterwards; a following read of r9 stalls.
5. Read r0 with opZeroIfR0_i=1 after r0 was written 0x55 -> operand 0; with the flag 0 -> 0x55.
6. With r4 pending, assert flush_i alongside a request -> stall_o=1, valid_o=0 next cycle, the request reading r4 is then accepted; a reset mid-stall -> all outputs 0 next cycle.

Source files
------------

// File: rtl/scoreboard_regfile.sv
// scoreboard_regfile: GPR file plus per-register pending-writeback scoreboard.
// Reads up to NUM_OPS operands per issued instruction, marks destinations
// pending, retires NUM_WB writebacks per cycle and optionally forwards
// same-cycle writeback data to reads.
// Ports:
//   clock_i, reset_i (sync, active high), flush_i
//   valid_i, opEnable_i, opAddr_i, opUse_i, opZeroIfR0_i  : issue request
//   wbValid_i, wbAddr_i, wbData_i                         : writeback ports
//   stall_o (comb)                                        : request refused
//   valid_o, operand_o, operandEnable_o, operandWb_o, destAddr_o : registered

// Per-slot hazard detection and operand selection.
module scoreboard_slot #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int BYPASS     = 1
) (
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [1:0]            opuse,
  input  logic                  zero_r0,
  input  logic                  pend,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] rf_data,
  input  logic                  byp_hit,
  input  logic [DATA_WIDTH-1:0] byp_data,
  output logic                  hazard,
  output logic [DATA_WIDTH-1:0] operand,
  output logic                  wb,
  output logic [ADDR_WIDTH-1:0] dest
);
  logic rd, wr, zf;
  assign rd = opuse[0];
  assign wr = opuse[1];
  assign zf = zero_r0 && (addr == '0);

  always_comb begin
    hazard = 1'b0;
    // RAW: a same-cycle writeback only rescues the read if it can be forwarded.
    if (en && rd && !zf && pend && !((BYPASS != 0) && clr)) hazard = 1'b1;
    // WAW: the old producer must retire (this cycle at latest) first.
    if (en && wr && pend && !clr) hazard = 1'b1;
  end

  always_comb begin
    operand = '0;
    if (en) begin
      if (!rd)                          operand = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, addr};
      else if (zf)                      operand = '0;
      else if ((BYPASS != 0) && byp_hit) operand = byp_data;
      else                              operand = rf_data;
    end
  end

  assign wb   = en & wr;
  assign dest = (en && wr) ? addr : '0;
endmodule

module scoreboard_regfile #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_OPS    = 3,
  parameter int NUM_WB     = 2,
  parameter int BYPASS     = 1
) (
  input  logic                             clock_i,
  input  logic                             reset_i,
  input  logic                             flush_i,
  input  logic                             valid_i,
  input  logic [NUM_OPS-1:0]               opEnable_i,
  input  logic [NUM_OPS*ADDR_WIDTH-1:0]    opAddr_i,
  input  logic [NUM_OPS*2-1:0]             opUse_i,
  input  logic [NUM_OPS-1:0]               opZeroIfR0_i,
  input  logic [NUM_WB-1:0]                wbValid_i,
  input  logic [NUM_WB*ADDR_WIDTH-1:0]     wbAddr_i,
  input  logic [NUM_WB*DATA_WIDTH-1:0]     wbData_i,
  output logic                             stall_o,
  output logic                             valid_o,
  output logic [NUM_OPS*DATA_WIDTH-1:0]    operand_o,
  output logic [NUM_OPS-1:0]               operandEnable_o,
  output logic [NUM_OPS-1:0]               operandWb_o,
  output logic [NUM_OPS*ADDR_WIDTH-1:0]    destAddr_o
);
  localparam int NUM_REGS = 2**ADDR_WIDTH;
  localparam int STAGES   = 1;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] rf;
  logic [NUM_REGS-1:0]                 pending, pend_nxt, wb_clr;

  logic [NUM_WB-1:0][ADDR_WIDTH-1:0]   wb_addr;
  logic [NUM_WB-1:0][DATA_WIDTH-1:0]   wb_data;
  logic [NUM_OPS-1:0][ADDR_WIDTH-1:0]  slot_addr, slot_dest;
  logic [NUM_OPS-1:0][1:0]             slot_use;
  logic [NUM_OPS-1:0][DATA_WIDTH-1:0]  slot_op, byp_data;
  logic [NUM_OPS-1:0]                  haz, slot_wb, byp_hit;
  logic [STAGES:1]                     vld_pipe;
  logic                                accept;

  assign wb_addr   = wbAddr_i;
  assign wb_data   = wbData_i;
  assign slot_addr = opAddr_i;
  assign slot_use  = opUse_i;

  always_comb begin
    wb_clr = '0;
    for (int j = 0; j < NUM_WB; j++)
      if (wbValid_i[j]) wb_clr[wb_addr[j]] = 1'b1;
  end

  for (genvar k = 0; k < NUM_OPS; k++) begin : g_slot
    // Ascending scan so the highest-index matching port wins.
    always_comb begin
      byp_hit[k]  = 1'b0;
      byp_data[k] = '0;
      for (int j = 0; j < NUM_WB; j++)
        if (wbValid_i[j] && (wb_addr[j] == slot_addr[k])) begin
          byp_hit[k]  = 1'b1;
          byp_data[k] = wb_data[j];
        end
    end

    scoreboard_slot #(
      .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .BYPASS(BYPASS)
    ) u_slot (
      .en      (opEnable_i[k]),
      .addr    (slot_addr[k]),
      .opuse   (slot_use[k]),
      .zero_r0 (opZeroIfR0_i[k]),
      .pend    (pending[slot_addr[k]]),
      .clr     (wb_clr[slot_addr[k]]),
      .rf_data (rf[slot_addr[k]]),
      .byp_hit (byp_hit[k]),
      .byp_data(byp_data[k]),
      .hazard  (haz[k]),
      .operand (slot_op[k]),
      .wb      (slot_wb[k]),
      .dest    (slot_dest[k])
    );
  end

  assign stall_o = valid_i & (flush_i | (|haz));
  assign accept  = valid_i & ~stall_o;

  // Issue set beats writeback clear (new producer); flush beats everything.
  always_comb begin
    pend_nxt = pending & ~wb_clr;
    if (accept)
      for (int k = 0; k < NUM_OPS; k++)
        if (slot_wb[k]) pend_nxt[slot_dest[k]] = 1'b1;
    if (flush_i) pend_nxt = '0;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rf              <= '0;
      pending         <= '0;
      vld_pipe        <= '0;
      operand_o       <= '0;
      operandEnable_o <= '0;
      operandWb_o     <= '0;
      destAddr_o      <= '0;
    end else begin
      for (int j = 0; j < NUM_WB; j++)
        if (wbValid_i[j]) rf[wb_addr[j]] <= wb_data[j];
      pending     <= pend_nxt;
      vld_pipe[1] <= accept;
      if (accept) begin
        operand_o       <= slot_op;
        operandEnable_o <= opEnable_i;
        operandWb_o     <= slot_wb;
        destAddr_o      <= slot_dest;
      end
    end
  end

  assign valid_o = vld_pipe[STAGES];
endmodule
